// File: rtl/link_conditioner.sv
// rtl/link_conditioner.sv - Link reference synchroniser, deglitcher, period meter, lock qualifier and Hz divider.
// Feeds link/swiptAlive/freq_rdy to the PLL core; f_meas is CLK_HZ/period for status and debug.
module link_conditioner #(
  parameter int CLK_HZ      = 100000000,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 4,
  parameter int MIN_PERIOD  = 1000,
  parameter int MAX_PERIOD  = 10000,
  parameter int TOL_CYC     = 25,
  parameter int LOCK_CNT    = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        link_raw,
  output logic        link,
  output logic        swiptAlive,
  output logic        freq_rdy,
  output logic [31:0] period,
  output logic [31:0] f_meas,
  output logic        f_valid
);

  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYC - 1);
  localparam logic [MW-1:0] LOCK_M      = MW'(LOCK_CNT);
  localparam logic [31:0]   MIN_W       = 32'(MIN_PERIOD);
  localparam logic [31:0]   MAX_W       = 32'(MAX_PERIOD);
  localparam logic [31:0]   TOL_W       = 32'(TOL_CYC);
  localparam logic [31:0]   TIMEOUT_W   = 32'(TIMEOUT_CYC);
  localparam logic [31:0]   CLK_W       = 32'(CLK_HZ);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [GW-1:0]          glitch_q;
  logic                   link_q, link_prev_q, rise_q;
  logic [31:0]            edge_cnt_q;
  state_t                 state_q;
  logic [MW-1:0]          match_q, match_d;
  logic [31:0]            prev_q;
  logic                   prev_vld_q;
  logic [31:0]            period_q;
  logic                   swipt_alive_q, freq_rdy_q;
  logic [31:0]            p_meas, diff;
  logic                   in_range, is_match, timeout, accept;

  logic                   div_busy_q;
  logic [4:0]             div_cnt_q;
  logic [31:0]            div_rem_q, div_quo_q, div_dsr_q;
  logic [31:0]            rem_d, quo_d;
  logic [32:0]            rem_sh, rem_sub;
  logic [31:0]            f_meas_q;
  logic                   f_valid_q;

  assign s          = sync_q[SYNC_STAGES-1];
  assign link       = link_q;
  assign swiptAlive = swipt_alive_q;
  assign freq_rdy   = freq_rdy_q;
  assign period     = period_q;
  assign f_meas     = f_meas_q;
  assign f_valid    = f_valid_q;

  always_ff @(posedge clk) begin
    if (nrst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], link_raw};
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      glitch_q    <= '0;
      link_q      <= 1'b0;
      link_prev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      link_prev_q <= link_q;
      rise_q      <= link_q & ~link_prev_q;
      if (s != link_q) begin
        if (glitch_q == GLITCH_LAST) begin
          link_q   <= ~link_q;
          glitch_q <= '0;
        end else begin
          glitch_q <= glitch_q + GW'(1);
        end
      end else begin
        glitch_q <= '0;
      end
    end
  end

  // The counter restarts at 0 on a rise, so the interval between rise pulses is count+1.
  always_comb begin
    p_meas   = edge_cnt_q + 32'd1;
    in_range = (p_meas >= MIN_W) && (p_meas <= MAX_W);
    diff     = (p_meas >= prev_q) ? (p_meas - prev_q) : (prev_q - p_meas);
    is_match = prev_vld_q && (diff <= TOL_W);
    match_d  = '0;
    if (is_match) match_d = (match_q == LOCK_M) ? LOCK_M : match_q + MW'(1);
    timeout  = (edge_cnt_q == TIMEOUT_W);
    accept   = rise_q && (state_q != IDLE) && in_range;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q       <= IDLE;
      edge_cnt_q    <= '0;
      match_q       <= '0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      period_q      <= '0;
      swipt_alive_q <= 1'b0;
      freq_rdy_q    <= 1'b0;
    end else begin
      if (rise_q)                       edge_cnt_q <= '0;
      else if (edge_cnt_q != TIMEOUT_W) edge_cnt_q <= edge_cnt_q + 32'd1;

      // A rise takes priority over a coincident timeout.
      if (rise_q) begin
        swipt_alive_q <= 1'b1;
        if (state_q == IDLE) begin
          state_q    <= ACQ;
          freq_rdy_q <= 1'b0;
        end else if (!in_range) begin
          match_q    <= '0;
          state_q    <= ACQ;
          freq_rdy_q <= 1'b0;
        end else begin
          period_q   <= p_meas;
          prev_q     <= p_meas;
          prev_vld_q <= 1'b1;
          match_q    <= match_d;
          if (match_d == LOCK_M) begin
            state_q    <= LOCKED;
            freq_rdy_q <= 1'b1;
          end else begin
            state_q    <= ACQ;
            freq_rdy_q <= 1'b0;
          end
        end
      end else if (timeout) begin
        state_q       <= IDLE;
        match_q       <= '0;
        prev_q        <= '0;
        prev_vld_q    <= 1'b0;
        swipt_alive_q <= 1'b0;
        freq_rdy_q    <= 1'b0;
      end
    end
  end

  // Restoring divide: the dividend shifts out of the quotient register MSB-first.
  always_comb begin
    rem_sh  = {div_rem_q, div_quo_q[31]};
    rem_sub = rem_sh - {1'b0, div_dsr_q};
    rem_d   = rem_sh[31:0];
    quo_d   = {div_quo_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, div_dsr_q}) begin
      rem_d = rem_sub[31:0];
      quo_d = {div_quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      div_busy_q <= 1'b0;
      div_cnt_q  <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_dsr_q  <= '0;
      f_meas_q   <= '0;
      f_valid_q  <= 1'b0;
    end else begin
      f_valid_q <= 1'b0;
      if (accept) begin
        div_busy_q <= 1'b1;
        div_cnt_q  <= '0;
        div_rem_q  <= '0;
        div_quo_q  <= CLK_W;
        div_dsr_q  <= p_meas;
      end else if (div_busy_q) begin
        div_rem_q <= rem_d;
        div_quo_q <= quo_d;
        div_cnt_q <= div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) begin
          div_busy_q <= 1'b0;
          f_meas_q   <= quo_d;
          f_valid_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_link_conditioner.sv
// tb/tb_link_conditioner.sv - Directed self-checking bench for link_conditioner.
module tb_link_conditioner;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        link_raw = 1'b0;
  logic        link, swiptAlive, freq_rdy, f_valid;
  logic [31:0] period, f_meas;
  int          n_checks = 0;
  int          n_fail = 0;

  link_conditioner #(.LOCK_CNT(4)) dut (
    .clk(clk), .nrst(nrst), .link_raw(link_raw),
    .link(link), .swiptAlive(swiptAlive), .freq_rdy(freq_rdy),
    .period(period), .f_meas(f_meas), .f_valid(f_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      link_raw = 1'b1;
      cyc(p / 2);
      link_raw = 1'b0;
      cyc(p - p / 2);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    link_raw = 1'b0;
    cyc(3);
    nrst = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      link_raw = ~link_raw;
      cyc(1);
    end
    n_checks++; if (link !== 1'b0) begin n_fail++; $display("FAIL rst_link: got %0b want 0", link); end
    n_checks++; if (swiptAlive !== 1'b0) begin n_fail++; $display("FAIL rst_alive: got %0b want 0", swiptAlive); end
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %0b want 0", freq_rdy); end
    n_checks++; if (period !== 32'd0) begin n_fail++; $display("FAIL rst_period: got %0d want 0", period); end
    n_checks++; if (f_meas !== 32'd0) begin n_fail++; $display("FAIL rst_fmeas: got %0d want 0", f_meas); end
    n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fvalid: got %0b want 0", f_valid); end
    link_raw = 1'b0;
    nrst = 1'b0;
    cyc(20);
    n_checks++; if (swiptAlive !== 1'b0) begin n_fail++; $display("FAIL post_rst_alive: got %0b want 0", swiptAlive); end
    n_checks++; if (link !== 1'b0) begin n_fail++; $display("FAIL post_rst_link: got %0b want 0", link); end
  endtask

  task automatic test_deglitch();
    logic seen;
    int   first;
    seen = 1'b0;
    link_raw = 1'b1;
    cyc(3);
    link_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (link === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch3_dropped: link high seen=%0b want 0", seen); end
    first = -1;
    link_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == 4) link_raw = 1'b0;
      if (first < 0 && link === 1'b1) first = k;
    end
    n_checks++; if (first != 6) begin n_fail++; $display("FAIL pulse4_latency: got %0d want 6", first); end
  endtask

  task automatic test_measure();
    int          pc, fc, fv_n;
    logic [31:0] fm;
    do_reset();
    wave(2500, 1);
    n_checks++; if (swiptAlive !== 1'b1) begin n_fail++; $display("FAIL first_rise_alive: got %0b want 1", swiptAlive); end
    n_checks++; if (period !== 32'd0) begin n_fail++; $display("FAIL first_rise_period: got %0d want 0", period); end
    pc = -1; fc = -1; fv_n = 0; fm = '0;
    link_raw = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if (c == 1250) link_raw = 1'b0;
      cyc(1);
      if (pc < 0 && period === 32'd2500) pc = c;
      if (f_valid === 1'b1) begin
        fv_n++;
        if (fc < 0) begin fc = c; fm = f_meas; end
      end
    end
    n_checks++; if (pc != 7) begin n_fail++; $display("FAIL period_latency: got %0d want 7", pc); end
    n_checks++; if (fc - pc != 32) begin n_fail++; $display("FAIL fvalid_delay: got %0d want 32", fc - pc); end
    n_checks++; if (fv_n != 1) begin n_fail++; $display("FAIL fvalid_pulses: got %0d want 1", fv_n); end
    n_checks++; if (fm !== 32'd40000) begin n_fail++; $display("FAIL fmeas_2500: got %0d want 40000", fm); end
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_after_2nd: got %0b want 0", freq_rdy); end
  endtask

  task automatic test_lock();
    wave(2500, 3);
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_3_matches: got %0b want 0", freq_rdy); end
    wave(2500, 1);
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_4_matches: got %0b want 1", freq_rdy); end
    n_checks++; if (swiptAlive !== 1'b1) begin n_fail++; $display("FAIL alive_locked: got %0b want 1", swiptAlive); end
  endtask

  task automatic test_step();
    wave(2520, 1);
    wave(2600, 1);
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_tol_step: got %0b want 1", freq_rdy); end
    n_checks++; if (period !== 32'd2520) begin n_fail++; $display("FAIL period_2520: got %0d want 2520", period); end
    n_checks++; if (f_meas !== 32'd39682) begin n_fail++; $display("FAIL fmeas_2520: got %0d want 39682", f_meas); end
    link_raw = 1'b1;
    cyc(7);
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_before_step: got %0b want 1", freq_rdy); end
    cyc(1);
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_after_step: got %0b want 0", freq_rdy); end
    n_checks++; if (period !== 32'd2600) begin n_fail++; $display("FAIL period_2600: got %0d want 2600", period); end
    cyc(1300 - 8);
    link_raw = 1'b0;
    cyc(1300);
    wave(2600, 3);
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0b want 0", freq_rdy); end
    wave(2600, 1);
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL relock_2600: got %0b want 1", freq_rdy); end
    n_checks++; if (f_meas !== 32'd38461) begin n_fail++; $display("FAIL fmeas_2600: got %0d want 38461", f_meas); end
  endtask

  task automatic test_reject();
    wave(500, 1);
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_before_short: got %0b want 1", freq_rdy); end
    wave(2600, 1);
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_short_reject: got %0b want 0", freq_rdy); end
    n_checks++; if (period !== 32'd2600) begin n_fail++; $display("FAIL period_held: got %0d want 2600", period); end
    n_checks++; if (swiptAlive !== 1'b1) begin n_fail++; $display("FAIL alive_reject: got %0b want 1", swiptAlive); end
    wave(2600, 3);
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_resume_early: got %0b want 0", freq_rdy); end
    wave(2600, 1);
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_resume: got %0b want 1", freq_rdy); end
  endtask

  task automatic test_timeout();
    cyc(17400);
    n_checks++; if (swiptAlive !== 1'b1) begin n_fail++; $display("FAIL alive_pre_timeout: got %0b want 1", swiptAlive); end
    n_checks++; if (freq_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_pre_timeout: got %0b want 1", freq_rdy); end
    cyc(20);
    n_checks++; if (swiptAlive !== 1'b0) begin n_fail++; $display("FAIL alive_timeout: got %0b want 0", swiptAlive); end
    n_checks++; if (freq_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_timeout: got %0b want 0", freq_rdy); end
    n_checks++; if (period !== 32'd2600) begin n_fail++; $display("FAIL period_timeout: got %0d want 2600", period); end
    n_checks++; if (f_meas !== 32'd38461) begin n_fail++; $display("FAIL fmeas_timeout: got %0d want 38461", f_meas); end
  endtask

  task automatic test_reset_mid_divide();
    int fv_n;
    do_reset();
    wave(2500, 1);
    link_raw = 1'b1;
    cyc(8);
    n_checks++; if (period !== 32'd2500) begin n_fail++; $display("FAIL mid_accept: got %0d want 2500", period); end
    cyc(10);
    link_raw = 1'b0;
    nrst = 1'b1;
    cyc(1);
    n_checks++; if (period !== 32'd0) begin n_fail++; $display("FAIL mid_rst_period: got %0d want 0", period); end
    n_checks++; if (swiptAlive !== 1'b0) begin n_fail++; $display("FAIL mid_rst_alive: got %0b want 0", swiptAlive); end
    n_checks++; if (link !== 1'b0) begin n_fail++; $display("FAIL mid_rst_link: got %0b want 0", link); end
    nrst = 1'b0;
    fv_n = 0;
    for (int c = 0; c < 60; c++) begin
      cyc(1);
      if (f_valid === 1'b1) fv_n++;
    end
    n_checks++; if (fv_n != 0) begin n_fail++; $display("FAIL mid_rst_fvalid: got %0d pulses want 0", fv_n); end
    n_checks++; if (f_meas !== 32'd0) begin n_fail++; $display("FAIL mid_rst_fmeas: got %0d want 0", f_meas); end
  endtask

  initial begin
    test_reset();
    test_deglitch();
    test_measure();
    test_lock();
    test_step();
    test_reject();
    test_timeout();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
